// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, unlocked-select code, allocator state.
package noc_pkg;

  localparam int unsigned PORT_L  = 0;
  localparam int unsigned PORT_N  = 1;
  localparam int unsigned PORT_E  = 2;
  localparam int unsigned PORT_S  = 3;
  localparam int unsigned PORT_W  = 4;

  // Crossbar select value for an unlocked output (equals the default port count)
  localparam int unsigned IN_NONE = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i (wrapping) wins.
module noc_rr_arbiter #(
  parameter int unsigned N     = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan N positions starting at the pointer; keep only the first hit
  always_comb begin
    int unsigned j;
    logic        found;
    logic [IDX_W-1:0] jx;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j  = (32'(ptr_i) + k) % N;
      jx = IDX_W'(j);
      if (!found && req_i[jx]) begin
        found     = 1'b1;
        gnt_o[jx] = 1'b1;
        idx_o     = jx;
      end
    end
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// Wormhole switch allocator: per-output round-robin lock from head to tail flit,
// crossbar selects and FIFO pop grants gated by downstream fullness.
module noc_switch_allocator #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned PORT_W    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS*PORT_W-1:0] req_dest,
  input  logic [NUM_PORTS-1:0]        req_tail,
  input  logic [NUM_PORTS-1:0]        out_full,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [NUM_PORTS-1:0]        out_valid,
  output logic [NUM_PORTS*PORT_W-1:0] out_sel,
  output logic                        err_bad_dest
);

  localparam logic [PORT_W-1:0] SEL_NONE = PORT_W'(NUM_PORTS);

  noc_pkg::alloc_state_t state_q [NUM_PORTS];
  noc_pkg::alloc_state_t state_d [NUM_PORTS];
  logic [PORT_W-1:0]     owner_q [NUM_PORTS];
  logic [PORT_W-1:0]     owner_d [NUM_PORTS];
  logic [PORT_W-1:0]     rr_q    [NUM_PORTS];
  logic [PORT_W-1:0]     rr_d    [NUM_PORTS];
  logic                  err_q;

  logic [PORT_W-1:0]     dest    [NUM_PORTS];
  logic [NUM_PORTS-1:0]  bad;
  logic [NUM_PORTS-1:0]  owned;
  logic [NUM_PORTS-1:0]  go;
  logic [NUM_PORTS-1:0]  cand    [NUM_PORTS];
  logic [NUM_PORTS-1:0]  arb_gnt [NUM_PORTS];
  logic [PORT_W-1:0]     arb_idx [NUM_PORTS];

  // Decode requests, ownership, arbitration candidates and per-output flit pass
  always_comb begin
    bad   = '0;
    owned = '0;
    go    = '0;
    grant = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      dest[i] = req_dest[i*PORT_W +: PORT_W];
      bad[i]  = req_valid[i] && (dest[i] >= SEL_NONE);
    end
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == noc_pkg::LOCKED) owned[owner_q[o]] = 1'b1;
    end
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      cand[o] = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        cand[o][i] = (state_q[o] == noc_pkg::IDLE) && req_valid[i] &&
                     (dest[i] == PORT_W'(o)) && !owned[i];
      end
      go[o] = (state_q[o] == noc_pkg::LOCKED) && req_valid[owner_q[o]] &&
              !out_full[o] && (dest[owner_q[o]] == PORT_W'(o));
      if (go[o]) grant[owner_q[o]] = 1'b1;
    end
  end

  assign out_valid    = go;
  assign err_bad_dest = err_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
    noc_rr_arbiter #(
      .N     (NUM_PORTS),
      .IDX_W (PORT_W)
    ) u_arb (
      .req_i (cand[g]),
      .ptr_i (rr_q[g]),
      .gnt_o (arb_gnt[g]),
      .idx_o (arb_idx[g])
    );
    // owner_q holds SEL_NONE whenever the output is unlocked, so it doubles as the select
    assign out_sel[g*PORT_W +: PORT_W] = owner_q[g];
  end

  // Per-output lock FSM next state: lock on arbitration win, release on granted tail
  always_comb begin
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      case (state_q[o])
        noc_pkg::IDLE: begin
          if (|arb_gnt[o]) begin
            state_d[o] = noc_pkg::LOCKED;
            owner_d[o] = arb_idx[o];
          end
        end
        noc_pkg::LOCKED: begin
          if (go[o] && req_tail[owner_q[o]]) begin
            state_d[o] = noc_pkg::IDLE;
            owner_d[o] = SEL_NONE;
            rr_d[o]    = (owner_q[o] == PORT_W'(NUM_PORTS - 1)) ? '0 : owner_q[o] + 1'b1;
          end
        end
        default: begin
          state_d[o] = noc_pkg::IDLE;
          owner_d[o] = SEL_NONE;
        end
      endcase
    end
  end

  // State registers with asynchronous reset dropping every lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= noc_pkg::IDLE;
        owner_q[o] <= SEL_NONE;
        rr_q[o]    <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
      end
      err_q <= |bad;
    end
  end

endmodule
